// File: rtl/soc_pkg.sv
// Shared types and constants for the SoC memory path.
package soc_pkg;

  localparam int DATA_W = 32;
  localparam int MASK_W = 4;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_AUX = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational 2-way round-robin chooser; the caller owns the last-grant state.
module rr_pick
  import soc_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  assign gnt_valid = |req;
  // On contention the requester that did not win last time goes first.
  assign gnt_idx   = (req == 2'b11) ? ~last_gnt : req[REQ_AUX];

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter in front of the single-port memory: IDLE -> ISSUE -> WAIT,
// one transaction per three cycles, read data routed back to the issuing master.
module mem_arbiter
  import soc_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic              m0_rstrb,
  input  logic [MASK_W-1:0] m0_wmask,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ready,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic              m1_rstrb,
  input  logic [MASK_W-1:0] m1_wmask,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rstrb,
  output logic [MASK_W-1:0] mem_wmask,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t state;
  logic       last_gnt;
  logic       gnt;
  logic       rd_op;

  logic [1:0] req;
  logic       gnt_valid;
  logic       gnt_idx;

  logic [ADDR_W-1:0] sel_addr;
  logic              sel_rstrb;
  logic [MASK_W-1:0] sel_wmask;
  logic [DATA_W-1:0] sel_wdata;

  assign req = {m1_rstrb | (|m1_wmask), m0_rstrb | (|m0_wmask)};

  rr_pick u_pick (
    .req       (req),
    .last_gnt  (last_gnt),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  assign sel_addr  = (gnt_idx == REQ_AUX) ? m1_addr  : m0_addr;
  assign sel_rstrb = (gnt_idx == REQ_AUX) ? m1_rstrb : m0_rstrb;
  assign sel_wmask = (gnt_idx == REQ_AUX) ? m1_wmask : m0_wmask;
  assign sel_wdata = (gnt_idx == REQ_AUX) ? m1_wdata : m0_wdata;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      last_gnt  <= REQ_AUX;
      gnt       <= REQ_CPU;
      rd_op     <= 1'b0;
      mem_addr  <= '0;
      mem_rstrb <= 1'b0;
      mem_wmask <= '0;
      mem_wdata <= '0;
      m0_ready  <= 1'b0;
      m1_ready  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            gnt       <= gnt_idx;
            mem_addr  <= sel_addr;
            mem_wmask <= sel_wmask;
            mem_wdata <= sel_wdata;
            // A nonzero mask wins over the read strobe.
            mem_rstrb <= sel_rstrb & ~(|sel_wmask);
            rd_op     <= sel_rstrb & ~(|sel_wmask);
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          mem_rstrb <= 1'b0;
          mem_wmask <= '0;
          m0_ready  <= (gnt == REQ_CPU);
          m1_ready  <= (gnt == REQ_AUX);
          state     <= WAIT;
        end
        WAIT: begin
          m0_ready <= 1'b0;
          m1_ready <= 1'b0;
          last_gnt <= gnt;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory data is only valid during WAIT, so it is gated rather than registered.
  assign m0_rdata = (m0_ready && rd_op) ? mem_rdata : '0;
  assign m1_rdata = (m1_ready && rd_op) ? mem_rdata : '0;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single-port `memory` instance between the `cpu` and a second bus master (UART loader / debug port). It sits between the masters and the memory in `soc`, serialises their read/write transactions, and routes each read response back to the requester that issued it. Round-robin grant prevents either master from starving the other.

## Interface
- `ADDR_W`, 32, address width forwarded to memory
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  synchronous, active-low reset
- `m0_addr`  in  ADDR_W  requester 0 (cpu) byte address
- `m0_rstrb`  in  1  requester 0 read request
- `m0_wmask`  in  4  requester 0 byte write enables; nonzero = write request
- `m0_wdata`  in  32  requester 0 write data
- `m0_rdata`  out  32  read data to requester 0, valid only with `m0_ready`
- `m0_ready`  out  1  one-cycle completion pulse for requester 0
- `m1_addr`, `m1_rstrb`, `m1_wmask`, `m1_wdata`, `m1_rdata`, `m1_ready`: same as above for requester 1
- `mem_addr`  out  ADDR_W  registered address to memory
- `mem_rstrb`  out  1  registered read strobe to memory
- `mem_wmask`  out  4  registered byte write mask to memory
- `mem_wdata`  out  32  registered write data to memory
- `mem_rdata`  in  32  memory read data, valid the cycle after `mem_rstrb`

## Operation
- Request: `mN_rstrb=1` or `mN_wmask!=0`. The requester holds addr/strobe/mask/data stable until it sees `mN_ready`. It then drops or changes the request no earlier than the next cycle.
- If both `mN_rstrb` and nonzero `mN_wmask` are set, the request is a write. `mem_rstrb` is driven 0.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE: arbitrate. No request: stay. One request: grant it. Both: grant the requester that did not win last (`last_gnt` register). Latch the granted index and that requester's addr/rstrb/wmask/wdata into the `mem_*` registers, then go to ISSUE.
  - ISSUE: `mem_*` are driven for exactly this one cycle. Go to WAIT.
  - WAIT: `mem_*` strobes are 0. Pulse `mN_ready` for the granted N. If the transaction is a read, `mN_rdata = mem_rdata`. Update `last_gnt = N`. Go to IDLE.
- `mN_rdata` is 0 whenever `mN_ready` is 0. It is also 0 on writes.
- The non-granted requester sees `ready=0` throughout. Its request remains pending.
- Arbitration occurs only in IDLE. A request still asserted during WAIT is never re-granted in that cycle.

## Timing
- Reset (`rst=0` at a clock edge):
  - state → IDLE, `last_gnt` → 1 (so m0 wins the first contention).
  - `mem_addr`, `mem_wdata` → 0; `mem_rstrb` → 0; `mem_wmask` → 0.
  - `m0_ready`, `m1_ready` → 0; `m0_rdata`, `m1_rdata` → 0.
- Reset mid-transaction: any in-flight transaction is dropped and no `ready` is issued. A write already strobed in ISSUE has landed in memory. The requester must reissue.
- Latency: request sampled in IDLE at edge T. `mem_*` are valid in cycle T+1 (ISSUE). `mN_ready` and `mN_rdata` are valid in cycle T+2 (WAIT).
- Throughput: one transaction per 3 cycles while requests are continuous.
- Contention fairness: with both requesting continuously, grants alternate 0,1,0,1…
- `mem_rstrb` and `mem_wmask` are never nonzero for more than one consecutive cycle.

## Structure
- Shared package `soc_pkg`:
  - FSM state enum (IDLE/ISSUE/WAIT).
  - Requester index constants `REQ_CPU=0`, `REQ_AUX=1`.
  - Data width 32 and mask width 4.
- One sub-module, `rr_pick`: a combinational 2-way round-robin chooser with inputs `req[1:0]`, `last_gnt` and outputs `gnt_valid`, `gnt_idx`. All state stays in `mem_arbiter`.

## Test plan
- Reset: hold `rst=0` for 2 cycles with both requesters active → all outputs 0, no `mem_rstrb`. After release, m0 is granted first.
- Single read: m0 reads `0x00000010`, memory returns `0xDEADBEEF` → `mem_rstrb` high in cycle T+1 only. `m0_ready=1` with `m0_rdata=0xDEADBEEF` in T+2. `m1_ready` and `m1_rdata` stay 0.
- Write: m1 writes `0x12345678` to `0x00000020` with `wmask=4'b0011` → one ISSUE cycle with `mem_wmask=0011`, `mem_rstrb=0`. `m1_ready` in T+2 with `m1_rdata=0`. A readback shows only the low halfword changed.
- Contention: both continuously read distinct addresses for 4 transactions → grant order 0,1,0,1. Each ready is 3 cycles apart. Each rdata is routed to the correct requester.
- Read+write on one port: m0 asserts `rstrb=1` with `wmask=4'b1111` → treated as a write, `mem_rstrb=0`.
- Reset mid-op: assert `rst=0` in ISSUE of an m1 read → no `m1_ready` pulse. FSM is in IDLE after reset. A reissued read completes normally.
